irq_dispatch_ctrl: RTL and testbench

IRQ_DISPATCH_CTRL -- requirements
Module: irq_dispatch_ctrl

---
 rtl/irq_dispatch_ctrl.sv | 141 ++++++++++++++
 tb/tb_irq_dispatch_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_dispatch_ctrl.sv
// Edge-triggered interrupt dispatcher: four sources, one presented/in-service at a time.
// Optional rotating priority is enabled by defining IRQ_ROUND_ROBIN_EN (fixed priority otherwise).
module irq_dispatch_ctrl #(
   parameter int N_IRQ = 4,
   parameter int ID_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_IRQ-1:0]  irq,
   input  logic [N_IRQ-1:0]  irq_mask,
   input  logic              int_ack,
   input  logic              eoi,
   output logic [ID_W-1:0]   int_id,
   output logic              int_valid,
   output logic              in_service,
   output logic [N_IRQ-1:0]  pending
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   state_t             state_r;
   state_t             state_nx_s;
   logic [N_IRQ-1:0]   irq_q_r;
   logic [N_IRQ-1:0]   pending_r;
   logic [N_IRQ-1:0]   pending_nx_s;
   logic [ID_W-1:0]    int_id_r;
   logic [ID_W-1:0]    int_id_nx_s;
   logic               int_valid_r;
   logic               in_service_r;
   logic [N_IRQ-1:0]   rise_s;
   logic [N_IRQ-1:0]   eligible_s;
   logic [N_IRQ-1:0]   ack_clr_s;
   logic [ID_W-1:0]    search_start_s;

   // Lowest offset from start wins; iterating downward lets the last hit be the closest one.
   function automatic logic [ID_W-1:0] pick(input logic [N_IRQ-1:0] elig,
                                            input logic [ID_W-1:0]  start);
      logic [ID_W-1:0] idx;
      logic [ID_W-1:0] win;
      win = start;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         idx = start + ID_W'(i);
         if (elig[idx]) begin
            win = idx;
         end else begin
            win = win;
         end
      end
      return win;
   endfunction

   assign rise_s     = irq & ~irq_q_r;
   assign eligible_s = pending_r & ~irq_mask;
   assign ack_clr_s  = {{(N_IRQ-1){1'b0}}, 1'b1} << int_id_r;

`ifdef IRQ_ROUND_ROBIN_EN
   logic [ID_W-1:0] rr_ptr_r;

   assign search_start_s = rr_ptr_r;

   // Rotation pointer moves just past the source whose service has completed.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr_r <= {ID_W{1'b0}};
      end else if ((state_r == SERVICE) && eoi) begin
         rr_ptr_r <= int_id_r + {{(ID_W-1){1'b0}}, 1'b1};
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end
`else
   assign search_start_s = {ID_W{1'b0}};
`endif

   // Next-state, winner selection and pending update.
   always_comb begin
      state_nx_s   = state_r;
      pending_nx_s = pending_r | rise_s;
      int_id_nx_s  = int_id_r;
      case (state_r)
         IDLE: begin
            if (eligible_s != {N_IRQ{1'b0}}) begin
               int_id_nx_s = pick(eligible_s, search_start_s);
               state_nx_s  = REQ;
            end else begin
               state_nx_s  = IDLE;
            end
         end
         REQ: begin
            // A fresh edge in the ack cycle re-arms the bit it is clearing.
            if (int_ack) begin
               pending_nx_s = (pending_r & ~ack_clr_s) | rise_s;
               state_nx_s   = SERVICE;
            end else if (irq_mask[int_id_r]) begin
               state_nx_s   = IDLE;
            end else begin
               state_nx_s   = REQ;
            end
         end
         SERVICE: begin
            if (eoi) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = SERVICE;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         irq_q_r      <= {N_IRQ{1'b0}};
         pending_r    <= {N_IRQ{1'b0}};
         int_id_r     <= {ID_W{1'b0}};
         int_valid_r  <= 1'b0;
         in_service_r <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         irq_q_r      <= irq;
         pending_r    <= pending_nx_s;
         int_id_r     <= int_id_nx_s;
         int_valid_r  <= (state_nx_s == REQ);
         in_service_r <= (state_nx_s == SERVICE);
      end
   end

   assign int_id     = int_id_r;
   assign int_valid  = int_valid_r;
   assign in_service = in_service_r;
   assign pending    = pending_r;

endmodule

// File: tb/tb_irq_dispatch_ctrl.sv
// Scoreboard bench for irq_dispatch_ctrl: expected IDs queued at stimulus, popped on presentation.
// The rotating-priority scenario follows IRQ_ROUND_ROBIN_EN the same way the design does.
module tb_irq_dispatch_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] irq;
   logic [3:0] irq_mask;
   logic       int_ack;
   logic       eoi;
   logic [1:0] int_id;
   logic       int_valid;
   logic       in_service;
   logic [3:0] pending;

   int         n_cmp;
   int         n_fail;
   logic [1:0] sb_q[$];

   irq_dispatch_ctrl #(.N_IRQ(4), .ID_W(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .irq        (irq),
      .irq_mask   (irq_mask),
      .int_ack    (int_ack),
      .eoi        (eoi),
      .int_id     (int_id),
      .int_valid  (int_valid),
      .in_service (in_service),
      .pending    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      irq      = 4'b0000;
      irq_mask = 4'b0000;
      int_ack  = 1'b0;
      eoi      = 1'b0;
      tick();
      tick();
      reset    = 1'b0;
   endtask

   task automatic wait_valid(output bit ok);
      int budget;
      budget = 0;
      while (int_valid !== 1'b1 && budget < 8) begin
         tick();
         budget++;
      end
      ok = (int_valid === 1'b1);
   endtask

   // Pops expected IDs, acks and eois each presentation, checking as it goes.
   task automatic drain(input int count, input string tag);
      bit ok;
      logic [1:0] exp;
      for (int k = 0; k < count; k++) begin
         wait_valid(ok);
         n_cmp++;
         if (!ok) begin
            n_fail++;
            $display("FAIL %s timeout: int_valid=%b required 1", tag, int_valid);
         end
         exp = (sb_q.size() > 0) ? sb_q.pop_front() : 2'bxx;
         n_cmp++;
         if (int_id !== exp) begin
            n_fail++;
            $display("FAIL %s id[%0d]: got %0d required %0d", tag, k, int_id, exp);
         end
         int_ack = 1'b1;
         tick();
         int_ack = 1'b0;
         n_cmp++;
         if (in_service !== 1'b1 || int_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ack[%0d]: in_service=%b int_valid=%b required 1 0", tag, k, in_service, int_valid);
         end
         eoi = 1'b1;
         tick();
         eoi = 1'b0;
         n_cmp++;
         if (in_service !== 1'b0 || int_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s eoi[%0d]: in_service=%b int_valid=%b required 0 0", tag, k, in_service, int_valid);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({int_valid, in_service, int_id, pending} !== 8'b0) begin
         n_fail++;
         $display("FAIL reset_state: got v=%b s=%b id=%0d p=%b required all 0", int_valid, in_service, int_id, pending);
      end
   endtask

   task automatic test_single();
      do_reset();
      irq = 4'b0001;
      sb_q.push_back(2'd0);
      tick();
      n_cmp++;
      if (pending !== 4'b0001 || int_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_edge0: pending=%b int_valid=%b required 0001 0", pending, int_valid);
      end
      tick();
      n_cmp++;
      if (int_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL single_latency: int_valid=%b required 1", int_valid);
      end
      drain(1, "single");
      n_cmp++;
      if (pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_pending: got %b required 0000", pending);
      end
      irq = 4'b0000;
   endtask

   task automatic test_fixed_order();
      do_reset();
      irq = 4'b1111;
      for (int i = 0; i < 4; i++) sb_q.push_back(2'(i));
      tick();
      n_cmp++;
      if (pending !== 4'b1111) begin
         n_fail++;
         $display("FAIL order_pending: got %b required 1111", pending);
      end
      drain(4, "order");
      n_cmp++;
      if (pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL order_final_pending: got %b required 0000", pending);
      end
      irq = 4'b0000;
   endtask

   task automatic test_no_preempt();
      do_reset();
      irq = 4'b0100;
      tick();
      tick();
      irq = 4'b0101;
      tick();
      n_cmp++;
      if (int_valid !== 1'b1 || int_id !== 2'd2 || pending !== 4'b0101) begin
         n_fail++;
         $display("FAIL no_preempt: v=%b id=%0d p=%b required 1 2 0101", int_valid, int_id, pending);
      end
      sb_q.push_back(2'd2);
      sb_q.push_back(2'd0);
      drain(2, "no_preempt");
      irq = 4'b0000;
   endtask

   task automatic test_mask_withdraw();
      do_reset();
      irq = 4'b0100;
      tick();
      tick();
      n_cmp++;
      if (int_valid !== 1'b1 || int_id !== 2'd2) begin
         n_fail++;
         $display("FAIL mask_present: v=%b id=%0d required 1 2", int_valid, int_id);
      end
      irq_mask = 4'b0100;
      tick();
      n_cmp++;
      if (int_valid !== 1'b0 || pending !== 4'b0100) begin
         n_fail++;
         $display("FAIL mask_withdraw: v=%b p=%b required 0 0100", int_valid, pending);
      end
      tick();
      n_cmp++;
      if (int_valid !== 1'b0 || in_service !== 1'b0) begin
         n_fail++;
         $display("FAIL mask_hold: v=%b s=%b required 0 0", int_valid, in_service);
      end
      irq_mask = 4'b0000;
      sb_q.push_back(2'd2);
      drain(1, "mask_unmask");
      irq = 4'b0000;
   endtask

   task automatic test_reedge_on_ack();
      do_reset();
      irq = 4'b0010;
      tick();
      tick();
      irq = 4'b0000;
      tick();
      n_cmp++;
      if (int_valid !== 1'b1 || int_id !== 2'd1) begin
         n_fail++;
         $display("FAIL reedge_present: v=%b id=%0d required 1 1", int_valid, int_id);
      end
      irq = 4'b0010;
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      n_cmp++;
      if (pending !== 4'b0010 || in_service !== 1'b1) begin
         n_fail++;
         $display("FAIL reedge_pending: p=%b s=%b required 0010 1", pending, in_service);
      end
      eoi = 1'b1;
      tick();
      eoi = 1'b0;
      tick();
      n_cmp++;
      if (int_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reedge_after_eoi: int_valid=%b required 1 two edges after eoi", int_valid);
      end
      sb_q.push_back(2'd1);
      drain(1, "reedge_redispatch");
      irq = 4'b0000;
   endtask

   task automatic test_rotation();
      do_reset();
      irq = 4'b1111;
      for (int i = 0; i < 4; i++) sb_q.push_back(2'(i));
      drain(4, "rot_all");
      irq = 4'b0000;
      tick();
      irq = 4'b1001;
      sb_q.push_back(2'd0);
      sb_q.push_back(2'd3);
      drain(2, "rot_03");
      irq = 4'b0000;
      tick();
      irq = 4'b0010;
      sb_q.push_back(2'd1);
      drain(1, "rot_1");
      irq = 4'b0000;
      tick();
      irq = 4'b1001;
`ifdef IRQ_ROUND_ROBIN_EN
      sb_q.push_back(2'd3);
      sb_q.push_back(2'd0);
`else
      sb_q.push_back(2'd0);
      sb_q.push_back(2'd3);
`endif
      drain(2, "rot_after_1");
      irq = 4'b0000;
   endtask

   task automatic test_reset_in_service();
      do_reset();
      irq = 4'b0100;
      tick();
      tick();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      n_cmp++;
      if (in_service !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_svc_setup: in_service=%b required 1", in_service);
      end
      reset = 1'b1;
      eoi   = 1'b1;
      tick();
      eoi   = 1'b0;
      n_cmp++;
      if ({int_valid, in_service, int_id, pending} !== 8'b0) begin
         n_fail++;
         $display("FAIL rst_svc_clear: v=%b s=%b id=%0d p=%b required all 0", int_valid, in_service, int_id, pending);
      end
      tick();
      reset = 1'b0;
      tick();
      n_cmp++;
      if (pending !== 4'b0100) begin
         n_fail++;
         $display("FAIL rst_release_pending: got %b required 0100", pending);
      end
      sb_q.push_back(2'd2);
      drain(1, "rst_release_dispatch");
      n_cmp++;
      if (pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_single_event: pending=%b required 0000", pending);
      end
      irq = 4'b0000;
   endtask

   // Concurrent monitor: presentation and service must be mutually exclusive.
   always @(negedge clk) begin
      if (reset === 1'b0 && int_valid === 1'b1 && in_service === 1'b1) begin
         n_fail++;
         $display("FAIL exclusive: int_valid=1 in_service=1 required not both");
      end
   end

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_single();
      test_fixed_order();
      test_no_preempt();
      test_mask_withdraw();
      test_reedge_on_ack();
      test_rotation();
      test_reset_in_service();
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_leftover: %0d entries required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
